// File: rtl/add_chunk_stage.sv
// One pipeline slice of the chunked adder: a CW-bit adder whose sum and
// carry are registered together with the slice's valid bit.
//
// Handshake: a bundle moves from producer to consumer on a rising clock
// edge exactly when valid and ready are both high. A producer holding
// valid keeps its data stable until that edge. ready never depends on the
// data. In this slice, up_ready is high whenever the slice is empty or
// its own content leaves downstream on the same edge.
module add_chunk_stage #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    output logic          dn_valid,
    input  logic          dn_ready,
    input  logic [CW-1:0] a_ck,
    input  logic [CW-1:0] b_ck,
    input  logic          c_prev,
    output logic          take,
    output logic [CW-1:0] sum_q,
    output logic          carry_q
);

    logic          valid_q;
    logic          valid_d;
    logic [CW-1:0] sum_d;
    logic          carry_d;
    logic [CW:0]   add_full;

    // Flow control for this slice plus the chunk add; data only moves on a transfer
    always_comb begin
        up_ready = !valid_q || dn_ready;
        take     = up_valid && up_ready;
        add_full = {1'b0, a_ck} + {1'b0, b_ck} + {{CW{1'b0}}, c_prev};
        valid_d  = up_ready ? up_valid : valid_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        if (take) begin
            sum_d   = add_full[CW-1:0];
            carry_d = add_full[CW];
        end
    end

    assign dn_valid = valid_q;

    // Slice state; reset empties the slice and clears its data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/pipelined_adder_nbit.sv
// W-bit add/subtract unit whose carry chain is cut into STAGES chunks.
// One chunk resolves per pipeline stage, so latency is STAGES cycles.
// Each stage carries the result chunks already computed below it and the
// operand chunks still waiting above it. Those shift fields shrink or grow
// by CHUNK bits per stage. Any empty stage pulls data forward even while
// the output is stalled, so bubbles collapse. The pipe holds up to STAGES
// operations.
module pipelined_adder_nbit #(
    parameter int W      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    localparam int CHUNK = W / STAGES;
    localparam int LAST  = STAGES - 1;

    if ((W % STAGES) != 0 || STAGES < 1 || STAGES > W) begin : g_bad_cfg
        $error("pipelined_adder_nbit: W must be a multiple of STAGES and 1 <= STAGES <= W");
    end

    logic [W-1:0] b_eff;
    logic         c_eff;
    logic         a_top_bit;
    logic         b_top_bit;
    logic         last_take;
    logic         a_msb_q;
    logic         a_msb_d;
    logic         b_msb_q;
    logic         b_msb_d;

    // Subtraction is a + ~b + ~c_in, so invert b and the carry once at the input
    always_comb begin
        b_eff = sub ? ~b : b;
        c_eff = sub ? ~c_in : c_in;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI_W = (STAGES - 1 - k) * CHUNK;

        logic [CHUNK-1:0] a_ck;
        logic [CHUNK-1:0] b_ck;
        logic [CHUNK-1:0] s_q;
        logic             c_prev;
        logic             v_up;
        logic             rdy_up;
        logic             v_dn;
        logic             rdy_dn;
        logic             take;
        logic             c_q;

        // Stage 0 sees the raw operands; later stages take the lowest waiting chunk
        if (k == 0) begin : g_src
            assign a_ck   = a[CHUNK-1:0];
            assign b_ck   = b_eff[CHUNK-1:0];
            assign c_prev = c_eff;
            assign v_up   = in_valid;
        end else begin : g_src
            assign a_ck   = g_stage[k-1].g_hi.a_hi_q[CHUNK-1:0];
            assign b_ck   = g_stage[k-1].g_hi.b_hi_q[CHUNK-1:0];
            assign c_prev = g_stage[k-1].c_q;
            assign v_up   = g_stage[k-1].v_dn;
        end

        // The last stage is released by the consumer
        if (k == LAST) begin : g_dn
            assign rdy_dn = out_ready;
        end else begin : g_dn
            assign rdy_dn = g_stage[k+1].rdy_up;
        end

        add_chunk_stage #(
            .CW(CHUNK)
        ) u_chunk (
            .clk     (clk),
            .rst_n   (rst_n),
            .up_valid(v_up),
            .up_ready(rdy_up),
            .dn_valid(v_dn),
            .dn_ready(rdy_dn),
            .a_ck    (a_ck),
            .b_ck    (b_ck),
            .c_prev  (c_prev),
            .take    (take),
            .sum_q   (s_q),
            .carry_q (c_q)
        );

        // Operand chunks above this stage, not yet consumed
        if (HI_W > 0) begin : g_hi
            logic [HI_W-1:0] a_hi_in;
            logic [HI_W-1:0] b_hi_in;
            logic [HI_W-1:0] a_hi_d;
            logic [HI_W-1:0] b_hi_d;
            logic [HI_W-1:0] a_hi_q;
            logic [HI_W-1:0] b_hi_q;

            if (k == 0) begin : g_in
                assign a_hi_in = a[W-1:CHUNK];
                assign b_hi_in = b_eff[W-1:CHUNK];
            end else begin : g_in
                assign a_hi_in = g_stage[k-1].g_hi.a_hi_q[HI_W+CHUNK-1:CHUNK];
                assign b_hi_in = g_stage[k-1].g_hi.b_hi_q[HI_W+CHUNK-1:CHUNK];
            end

            // Upper operand chunks advance together with this stage's slice
            always_comb begin
                a_hi_d = a_hi_q;
                b_hi_d = b_hi_q;
                if (take) begin
                    a_hi_d = a_hi_in;
                    b_hi_d = b_hi_in;
                end
            end

            // Upper operand shift field
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else begin
                    a_hi_q <= a_hi_d;
                    b_hi_q <= b_hi_d;
                end
            end
        end

        // Result chunks already resolved below this stage
        if (k > 0) begin : g_lo
            logic [k*CHUNK-1:0] lo_in;
            logic [k*CHUNK-1:0] lo_d;
            logic [k*CHUNK-1:0] lo_q;

            if (k == 1) begin : g_in
                assign lo_in = g_stage[0].s_q;
            end else begin : g_in
                assign lo_in = {g_stage[k-1].s_q, g_stage[k-1].g_lo.lo_q};
            end

            // Lower result chunks advance together with this stage's slice
            always_comb begin
                lo_d = lo_q;
                if (take) begin
                    lo_d = lo_in;
                end
            end

            // Lower result shift field
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lo_q <= '0;
                end else begin
                    lo_q <= lo_d;
                end
            end
        end
    end

    assign last_take = g_stage[LAST].take;
    assign a_top_bit = g_stage[LAST].a_ck[CHUNK-1];
    assign b_top_bit = g_stage[LAST].b_ck[CHUNK-1];

    // Operand sign bits ride with the final slice so overflow follows the held result
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        if (last_take) begin
            a_msb_d = a_top_bit;
            b_msb_d = b_top_bit;
        end
    end

    // Sign bits of the operation sitting in the output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    if (STAGES == 1) begin : g_sum
        assign sum = g_stage[0].s_q;
    end else begin : g_sum
        assign sum = {g_stage[LAST].s_q, g_stage[LAST].g_lo.lo_q};
    end

    assign in_ready  = g_stage[0].rdy_up;
    assign out_valid = g_stage[LAST].v_dn;
    assign c_out     = g_stage[LAST].c_q;
    // Same-sign operands giving an opposite-sign result is a signed overflow
    assign ovf       = (a_msb_q == b_msb_q) && (sum[W-1] != a_msb_q);

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Bench for pipelined_adder_nbit.
// The main unit is W=16, STAGES=4.
// Two companion units (STAGES=1, STAGES=16) share the input bus, with
// out_ready tied high.
// Expected results come from integer arithmetic on the operands.
module tb_pipelined_adder_nbit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_ready;
  logic        xo_ready;

  logic        in_ready, out_valid, c_out, ovf;
  logic [15:0] sum;
  logic        x1_ir, x1_ov, x1_c, x1_ovf;
  logic [15:0] x1_sum;
  logic        x16_ir, x16_ov, x16_c, x16_ovf;
  logic [15:0] x16_sum;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit lat_chk  = 0;
  int pops     = 0;

  logic [17:0] exp_q[$];
  int          stamp_q[$];
  logic [17:0] x1_q[$];
  int          x1_t[$];
  logic [17:0] x16_q[$];
  int          x16_t[$];
  bit          held_v = 0;
  logic [17:0] held_r;

  pipelined_adder_nbit #(.W(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  pipelined_adder_nbit #(.W(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x1_ir),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(x1_ov), .out_ready(xo_ready),
    .sum(x1_sum), .c_out(x1_c), .ovf(x1_ovf)
  );

  pipelined_adder_nbit #(.W(16), .STAGES(16)) dut_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x16_ir),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(x16_ov), .out_ready(xo_ready),
    .sum(x16_sum), .c_out(x16_c), .ovf(x16_ovf)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Returns {ovf, c_out, sum} from integer arithmetic.
  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic s);
    int sx, sy, cv, r_s, r_u;
    logic v, c;
    sx  = $signed(x);
    sy  = $signed(y);
    cv  = ci ? 1 : 0;
    r_s = s ? (sx - sy - cv) : (sx + sy + cv);
    v   = (r_s > 32767) || (r_s < -32768);
    r_u = s ? (int'(x) - int'(y) - cv) : (int'(x) + int'(y) + cv);
    c   = s ? (r_u >= 0) : (r_u > 65535);
    return {v, c, r_u[15:0]};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: main unit ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stamp_q.delete();
      held_v = 0;
    end else begin
      check("in_ready", in_ready, (exp_q.size() == 4 && !out_ready) ? 0 : 1);
      if (held_v) begin
        check("held_valid", out_valid, 1);
        check("held_result", {ovf, c_out, sum}, held_r);
      end
      if (exp_q.size() == 0) begin
        check("out_valid_when_empty", out_valid, 0);
      end else if (out_valid && out_ready) begin
        logic [17:0] e;
        int t;
        e = exp_q.pop_front();
        t = stamp_q.pop_front();
        pops++;
        check("result", {ovf, c_out, sum}, e);
        if (lat_chk) check("latency", cyc - t, 4);
      end
      held_v = out_valid && !out_ready;
      held_r = {ovf, c_out, sum};
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_op(a, b, c_in, sub));
        stamp_q.push_back(cyc);
      end
    end
  end

  // ---------------- scoreboard: STAGES=1 and STAGES=16 units ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      x1_q.delete();
      x1_t.delete();
      x16_q.delete();
      x16_t.delete();
    end else begin
      if (x1_q.size() == 0) begin
        check("s1_out_valid_when_empty", x1_ov, 0);
      end else if (x1_ov) begin
        check("s1_result", {x1_ovf, x1_c, x1_sum}, x1_q.pop_front());
        check("s1_latency", cyc - x1_t.pop_front(), 1);
      end
      if (x16_q.size() == 0) begin
        check("s16_out_valid_when_empty", x16_ov, 0);
      end else if (x16_ov) begin
        check("s16_result", {x16_ovf, x16_c, x16_sum}, x16_q.pop_front());
        check("s16_latency", cyc - x16_t.pop_front(), 16);
      end
      if (in_valid && x1_ir) begin
        x1_q.push_back(ref_op(a, b, c_in, sub));
        x1_t.push_back(cyc);
      end
      if (in_valid && x16_ir) begin
        x16_q.push_back(ref_op(a, b, c_in, sub));
        x16_t.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_one(input string name, input logic [15:0] xa, input logic [15:0] xb,
                          input logic ci, input logic s, input logic [17:0] exp);
    int k;
    bit got;
    out_ready = 1;
    in_valid = 1;
    a = xa;
    b = xb;
    c_in = ci;
    sub = s;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    k = 0;
    got = 0;
    while (!got && k < 12) begin
      @(negedge clk);
      k++;
      got = out_valid;
    end
    check({name, "_latency"}, k, 4);
    check(name, {ovf, c_out, sum}, exp);
    @(posedge clk); #1;
  endtask

  task automatic run_ops(input int n, input int pv, input int pr);
    int sent = 0;
    int g = 0;
    bit pend = 0;
    logic [15:0] pa, pb;
    logic pc, ps;
    pa = 0; pb = 0; pc = 0; ps = 0;
    while (sent < n && g < 20000) begin
      if (!pend) begin
        pa = rnd16();
        pb = rnd16();
        pc = 1'($urandom_range(1));
        ps = 1'($urandom_range(1));
      end
      in_valid = pend || ($urandom_range(99) < pv);
      if (in_valid) begin
        a = pa; b = pb; c_in = pc; sub = ps;
      end else begin
        a = 16'($urandom); b = 16'($urandom);
        c_in = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      end
      out_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      pend = in_valid && !in_ready;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 0;
    check("run_ops_sent", sent, n);
  endtask

  task automatic drain();
    int g = 0;
    in_valid = 0;
    out_ready = 1;
    while ((exp_q.size() != 0 || x1_q.size() != 0 || x16_q.size() != 0) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_in_budget", (g < 200) ? 1 : 0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int p0;
    rst_n = 0; in_valid = 0; a = 0; b = 0; c_in = 0; sub = 0;
    out_ready = 0; xo_ready = 1;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_s1_out_valid", x1_ov, 0);
    check("rst_s16_out_valid", x16_ov, 0);
    @(posedge clk); #2;
    rst_n = 1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    // Model pinned by hand-computed values
    check("model_ffff_plus_1", ref_op(16'hFFFF, 16'h0001, 1'b0, 1'b0), 18'h10000);
    check("model_8000_minus_1", ref_op(16'h8000, 16'h0001, 1'b0, 1'b1), 18'h37FFF);
    check("model_7fff_plus_1", ref_op(16'h7FFF, 16'h0001, 1'b0, 1'b0), 18'h28000);
    check("model_5_minus_7_borrow", ref_op(16'h0005, 16'h0007, 1'b1, 1'b1), 18'h0FFFD);

    // Directed literals
    lat_chk = 1;
    send_one("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
    send_one("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
    send_one("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    send_one("sub_5_7_bin", 16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0FFFD);
    drain();

    // Back-to-back streaming
    run_ops(100, 100, 100);
    drain();
    lat_chk = 0;

    // Backpressure: exactly four accepted while output is blocked
    out_ready = 0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      a = rnd16(); b = rnd16();
      c_in = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("bp_accepts", acc, 4);
    check("bp_in_ready_low", in_ready, 0);
    repeat (5) @(posedge clk);
    #1;
    p0 = pops;
    drain();
    check("bp_released_results", pops - p0, 4);

    // Random bubbles on both sides
    run_ops(1000, 50, 50);
    drain();

    // Reset with operations in flight
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      a = rnd16(); b = rnd16();
      c_in = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(posedge clk); #3;
    check("pre_reset_out_valid", out_valid, 1);
    rst_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_c_out", c_out, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_s1_out_valid", x1_ov, 0);
    check("midrst_s16_out_valid", x16_ov, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    repeat (20) @(posedge clk);
    #1;

    // Traffic after reset
    run_ops(200, 70, 70);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
